// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_if
// Brief    : Control-unit <-> mult/div sequencer request and status bundle.
// Revision : 1.0
// ============================================================================
interface muldiv_sequencer_if;
    logic        mult_req;
    logic        div_req;
    logic [31:0] divisor;
    logic        mult_init;
    logic        div_init;
    logic        hl_src;
    logic        hl_load;
    logic        busy;
    logic        done;
    logic        div_zero_exc;

    modport master (
        output mult_req, div_req, divisor,
        input  mult_init, div_init, hl_src, hl_load, busy, done, div_zero_exc
    );

    modport slave (
        input  mult_req, div_req, divisor,
        output mult_init, div_init, hl_src, hl_load, busy, done, div_zero_exc
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Starts the multiply/divide unit, counts its latency, loads HI/LO.
// Revision : 1.0
// ============================================================================
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  wire logic         clk,
    input  wire logic         reset,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_EXC   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    logic             r_op_mult;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mult_init;
    logic             r_div_init;
    logic             r_hl_src;
    logic             r_hl_load;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero_exc;

    logic w_divisor_nz;
    assign w_divisor_nz = (bus.divisor != 32'd0);

    // Every output is a register set on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_op_mult      <= 1'b0;
            r_cnt          <= '0;
            r_mult_init    <= 1'b0;
            r_div_init     <= 1'b0;
            r_hl_src       <= 1'b0;
            r_hl_load      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_div_zero_exc <= 1'b0;
        end else begin
            r_mult_init    <= 1'b0;
            r_div_init     <= 1'b0;
            r_hl_load      <= 1'b0;
            r_done         <= 1'b0;
            r_div_zero_exc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.mult_req) begin
                        r_state     <= S_START;
                        r_op_mult   <= 1'b1;
                        r_hl_src    <= 1'b1;
                        r_mult_init <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (bus.div_req) begin
                        r_busy <= 1'b1;
                        if (w_divisor_nz) begin
                            r_state    <= S_START;
                            r_op_mult  <= 1'b0;
                            r_hl_src   <= 1'b0;
                            r_div_init <= 1'b1;
                        end else begin
                            r_state        <= S_EXC;
                            r_div_zero_exc <= 1'b1;
                            r_done         <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_cnt   <= r_op_mult ? c_mult_load : c_div_load;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // Exit at zero so the counter never wraps.
                    if (r_cnt == '0) begin
                        r_state   <= S_WRITE;
                        r_hl_load <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE, S_EXC: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mult_init    = r_mult_init;
    assign bus.div_init     = r_div_init;
    assign bus.hl_src       = r_hl_src;
    assign bus.hl_load      = r_hl_load;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.div_zero_exc = r_div_zero_exc;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Two sequencers (32/32 and 5/1 latency) against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus0 ();
    muldiv_sequencer_if bus1 ();

    muldiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    muldiv_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(1), .CNT_W(6)) u_min (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: one accepted operation per instance, described by kind and accept cycle.
    // kind 0 = none, 1 = multiply, 2 = divide, 3 = divide-by-zero exception.
    int   lat_m  [2] = '{32, 5};
    int   lat_d  [2] = '{32, 1};
    int   m_kind [2];
    int   m_acc  [2];
    int   m_end  [2];
    logic m_src  [2];

    // Bit order: mult_init, div_init, hl_src, hl_load, busy, done, div_zero_exc
    function automatic logic [6:0] obs(input int i);
        if (i == 0)
            return {bus0.mult_init, bus0.div_init, bus0.hl_src, bus0.hl_load,
                    bus0.busy, bus0.done, bus0.div_zero_exc};
        return {bus1.mult_init, bus1.div_init, bus1.hl_src, bus1.hl_load,
                bus1.busy, bus1.done, bus1.div_zero_exc};
    endfunction

    function automatic logic [6:0] expv(input int i, input int t);
        logic [6:0] v;
        int a, n;
        v    = '0;
        v[4] = m_src[i];
        a    = m_acc[i];
        if (m_kind[i] == 3 && t == a + 1) begin
            v[2] = 1'b1;
            v[1] = 1'b1;
            v[0] = 1'b1;
        end else if (m_kind[i] == 1 || m_kind[i] == 2) begin
            n = (m_kind[i] == 1) ? lat_m[i] : lat_d[i];
            if (t == a + 1) v[(m_kind[i] == 1) ? 6 : 5] = 1'b1;
            if (t >= a + 1 && t <= a + n + 3) v[2] = 1'b1;
            if (t == a + n + 2) v[3] = 1'b1;
            if (t == a + n + 3) v[1] = 1'b1;
        end
        return v;
    endfunction

    task automatic step(input logic m, input logic d, input logic [31:0] dv, input logic r);
        logic [6:0] o, e;
        bus0.mult_req = m;  bus0.div_req = d;  bus0.divisor = dv;
        bus1.mult_req = m;  bus1.div_req = d;  bus1.divisor = dv;
        reset = r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            o = obs(i);
            e = expv(i, cyc);
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL outputs inst%0d cycle=%0d observed=%b expected=%b (init_m,init_d,src,load,busy,done,exc)",
                       i, cyc, o, e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_kind[i] = 0;
                m_src[i]  = 1'b0;
                m_end[i]  = cyc + 1;
            end else if (cyc >= m_end[i]) begin
                if (m) begin
                    m_kind[i] = 1;  m_acc[i] = cyc;  m_src[i] = 1'b1;
                    m_end[i]  = cyc + lat_m[i] + 4;
                end else if (d && dv != 32'd0) begin
                    m_kind[i] = 2;  m_acc[i] = cyc;  m_src[i] = 1'b0;
                    m_end[i]  = cyc + lat_d[i] + 4;
                end else if (d) begin
                    m_kind[i] = 3;  m_acc[i] = cyc;
                    m_end[i]  = cyc + 2;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus0.mult_req = 1'b0;  bus0.div_req = 1'b0;  bus0.divisor = 32'd0;
        bus1.mult_req = 1'b0;  bus1.div_req = 1'b0;  bus1.divisor = 32'd0;
        for (int i = 0; i < 2; i++) begin
            m_kind[i] = 0;  m_acc[i] = 0;  m_end[i] = 0;  m_src[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset held three cycles with a multiply request pending
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'd0, 1'b1);
        idle(2);

        // Plain multiply
        step(1'b1, 1'b0, 32'd0, 1'b0);
        idle(40);

        // Divide by zero
        step(1'b0, 1'b1, 32'd0, 1'b0);
        idle(4);

        // Simultaneous requests with zero divisor, then a stray divide in cycle 10
        step(1'b1, 1'b1, 32'd0, 1'b0);
        idle(9);
        step(1'b0, 1'b1, 32'd5, 1'b0);
        idle(40);

        // Reset mid-divide, new multiply two cycles later
        step(1'b0, 1'b1, 32'd7, 1'b0);
        idle(14);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        idle(40);

        // Back-to-back divide at the minimum latency boundary
        step(1'b0, 1'b1, 32'd3, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 32'd9, 1'b0);
        idle(40);

        // Request held through the done cycle and into the following idle cycle
        step(1'b1, 1'b0, 32'd0, 1'b0);
        idle(34);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        idle(40);

        // Randomised traffic, including occasional resets and zero divisors
        for (int k = 0; k < 600; k++) begin
            logic        rm, rd, rr;
            logic [31:0] rv;
            rm = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 4) == 0);
            rv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rr = ($urandom_range(0, 90) == 0);
            step(rm, rd, rv, rr);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the multicycle multiply and divide units and the HI/LO register pair. It sits between the control unit and the mult/div datapath. It accepts a one-cycle request, issues the unit start pulse and counts the unit's fixed latency. It then loads HI/LO through the hi/lo source muxes and returns a completion pulse. Divide-by-zero is caught before the divider starts and is reported as an exception.

## Interface
Parameters:
- MULT_CYCLES, 32, multiplier compute latency in cycles; must be at least 1.
- DIV_CYCLES, 32, divider compute latency in cycles; must be at least 1.
- CNT_W, 6, latency counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- mult_req  in  1  one-cycle request to start a multiply; sampled only in IDLE.
- div_req  in  1  one-cycle request to start a divide; sampled only in IDLE.
- divisor  in  32  divide operand B, sampled in the same cycle as div_req.
- mult_init  out  1  one-cycle start pulse to the multiplier.
- div_init  out  1  one-cycle start pulse to the divider.
- hl_src  out  1  hi/lo mux select: 0 = divider result, 1 = multiplier result.
- hl_load  out  1  one-cycle load enable for the HI and LO registers.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse.
- div_zero_exc  out  1  one-cycle divide-by-zero exception pulse.

## Operation
State machine states: IDLE, START, RUN, WRITE, DONE, EXC.

- **IDLE**
  - mult_req=1: latch op=MULT, go to START.
  - div_req=1 and divisor≠0: latch op=DIV, go to START.
  - div_req=1 and divisor==0: go to EXC.
  - mult_req and div_req both high: multiply wins and div_req is dropped; no exception is raised even if divisor==0.
- **START**
  - Assert mult_init or div_init according to op.
  - Load the counter with (op==MULT ? MULT_CYCLES : DIV_CYCLES)-1.
  - Go to RUN.
- **RUN**
  - Counter==0: go to WRITE.
  - Otherwise decrement the counter.
  - RUN therefore lasts exactly N cycles.
- **WRITE**: hl_load=1, then go to DONE.
- **DONE**: done=1, then go to IDLE.
- **EXC**: div_zero_exc=1 and done=1, then go to IDLE. No div_init and no hl_load are issued.
- **hl_src**
  - Registered; 1 for MULT, 0 for DIV.
  - Updated only on the IDLE→START transition.
  - Held stable from START through DONE and afterwards until the next accepted request.
- **busy**: 1 in START, RUN, WRITE, DONE and EXC; 0 in IDLE.
- **Requests while busy**: ignored; there is no queueing.
- **Counter arithmetic**: unsigned and CNT_W wide. The counter never underflows, because the RUN exit is taken at 0.

## Timing
- All outputs are registered or decoded from the state register, with no combinational path from the inputs.
- Reset values: every output is 0, hl_src=0, state=IDLE, counter=0.
- Reset asserted mid-operation: on the next edge the block is in IDLE with all outputs at 0. No hl_load or done pulse is emitted for the aborted operation.
- Cycle numbering below: request sampled in cycle 0 with N = unit latency.
  - Cycle 1: init pulse.
  - Cycles 2..N+1: RUN.
  - Cycle N+2: hl_load.
  - Cycle N+3: done.
  - Cycle N+4: back in IDLE, new request accepted.
- With N=32: init in cycle 1, hl_load in cycle 34, done in cycle 35.
- Divide-by-zero: div_zero_exc and done both assert in cycle 1; IDLE again in cycle 2.
- Back-to-back: a request held high during the done cycle is ignored. A request in the first IDLE cycle after done is accepted.

## Test plan
- **Reset**: hold reset 3 cycles with mult_req=1 → all outputs 0, no mult_init, busy=0.
- **Multiply, MULT_CYCLES=32**: pulse mult_req in cycle 0 → mult_init=1 in cycle 1 only, hl_src=1 from cycle 1, hl_load=1 in cycle 34 only, done=1 in cycle 35 only, busy=1 for cycles 1–35.
- **Divide-by-zero**: div_req=1 with divisor=0 → div_zero_exc=1 and done=1 in cycle 1 only, div_init and hl_load never assert, busy=1 in cycle 1 only.
- **Conflicts**: mult_req and div_req high together with divisor=0 → multiply runs (mult_init in cycle 1) and div_zero_exc stays 0. A further div_req pulse in cycle 10 is ignored (no second div_init).
- **Reset mid-operation**: divide with divisor=7, assert reset in cycle 15 → IDLE in cycle 16 with all outputs 0 and no hl_load ever. A new mult_req in cycle 17 gives mult_init in cycle 18.
- **Minimum latency and back-to-back**: DIV_CYCLES=1 → div_init in cycle 1, RUN in cycle 2, hl_load in cycle 3, done in cycle 4. A div_req in cycle 5 gives div_init in cycle 6.
